fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the decode stage. Owns the program counter, drives a single-outstanding request/response port to instruction memory, absorbs responses that return while decode is stalled, and registers the IF/ID pipeline outputs `instr_IF`, `pc_IF` and `pcnext_IF`. Branch and jump redirects from EX kill in-flight fetches and insert NOP bubbles.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_if.sv | 23 ++
 rtl/fetch_hold_buf.sv | 48 ++++
 rtl/fetch_stage.sv | 169 ++++++++++++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the RV32I instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        WAIT  = 3'd1,
        HOLD  = 3'd2,
        DROP  = 3'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Single-outstanding instruction-memory request/response port.
interface fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry instruction+PC buffer that absorbs a response returning while decode is stalled.
module fetch_hold_buf (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q,    pc_d;

    // Clear wins: a redirect in the same cycle as a capture must not keep stale data.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = instr_in;
            pc_d    = pc_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC, single-outstanding imem FSM, IF/ID registers.
// Optional perf counters when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    fetch_if.master     imem,
    output logic [31:0] instr_IF,
    output logic [31:0] pc_IF,
    output logic [31:0] pcnext_IF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q,     pc_d;
    logic [31:0]  instr_q,  instr_d;
    logic [31:0]  pcif_q,   pcif_d;
    logic [31:0]  pcnext_q, pcnext_d;

    logic         req;
    logic [31:0]  addr;
    logic [31:0]  pc_plus4;

    logic         hb_load, hb_clear, hb_valid;
    logic [31:0]  hb_instr, hb_pc;

    assign pc_plus4 = pc_q + 32'd4;

    fetch_hold_buf u_hold_buf (
        .clk      (clk),
        .rstn     (rstn),
        .load     (hb_load),
        .clear    (hb_clear),
        .instr_in (imem.imem_rdata),
        .pc_in    (pc_q),
        .valid    (hb_valid),
        .instr    (hb_instr),
        .pc       (hb_pc)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pcif_d   = pcif_q;
        pcnext_d = pcnext_q;
        req      = 1'b0;
        addr     = pc_q;
        hb_load  = 1'b0;
        hb_clear = 1'b0;

        if (redirect) begin
            pc_d     = redirect_pc & ~32'd3;
            instr_d  = NOP_INSTR;
            hb_clear = 1'b1;
            if ((state_q == WAIT || state_q == DROP) && !imem.imem_rvalid)
                state_d = DROP;
            else
                state_d = FETCH;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (!stall) begin
                        req     = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        pc_d = pc_plus4;
                        if (stall) begin
                            hb_load = 1'b1;
                            state_d = HOLD;
                        end else begin
                            // Back-to-back: consume the response and request pc+4 in one cycle.
                            instr_d  = imem.imem_rdata;
                            pcif_d   = pc_q;
                            pcnext_d = pc_plus4;
                            req      = 1'b1;
                            addr     = pc_plus4;
                        end
                    end else if (!stall) begin
                        instr_d = NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if (hb_valid) begin
                            instr_d  = hb_instr;
                            pcif_d   = hb_pc;
                            pcnext_d = hb_pc + 32'd4;
                        end
                        hb_clear = 1'b1;
                        req      = 1'b1;
                        state_d  = WAIT;
                    end
                end
                DROP: begin
                    if (imem.imem_rvalid)
                        state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pcif_q   <= '0;
            pcnext_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pcif_q   <= pcif_d;
            pcnext_q <= pcnext_d;
        end
    end

    // Keep the port quiet while reset is held even though FETCH would otherwise request.
    assign imem.imem_req  = req & rstn;
    assign imem.imem_addr = addr;

    assign instr_IF  = instr_q;
    assign pc_IF     = pcif_q;
    assign pcnext_IF = pcnext_q;

`ifdef FETCH_PERF_CNT_EN
    logic        load_real, load_bubble;
    logic [31:0] perf_fetch_cnt_q,  perf_fetch_cnt_d;
    logic [31:0] perf_bubble_cnt_q, perf_bubble_cnt_d;

    assign load_real   = !redirect && !stall &&
                         ((state_q == WAIT && imem.imem_rvalid) || (state_q == HOLD && hb_valid));
    assign load_bubble = redirect || (state_q == WAIT && !imem.imem_rvalid && !stall);

    always_comb begin
        perf_fetch_cnt_d  = perf_fetch_cnt_q  + {31'd0, load_real};
        perf_bubble_cnt_d = perf_bubble_cnt_q + {31'd0, load_bubble};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_fetch_cnt_q  <= '0;
            perf_bubble_cnt_q <= '0;
        end else begin
            perf_fetch_cnt_q  <= perf_fetch_cnt_d;
            perf_bubble_cnt_q <= perf_bubble_cnt_d;
        end
    end

    assign perf_fetch_cnt  = perf_fetch_cnt_q;
    assign perf_bubble_cnt = perf_bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle vector table plus a random-stall scoreboard stream.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rstn;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_IF, pc_IF, pcnext_IF;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

    fetch_if imem ();

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .instr_IF    (instr_IF),
        .pc_IF       (pc_IF),
        .pcnext_IF   (pcnext_IF)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total  = 0;
    int unsigned passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[27:0], 4'h7};
    endfunction

    typedef struct {
        logic        st;
        logic        red;
        logic [31:0] rpc;
        logic        rv;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcn;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcn;
    } exp_t;

    vec_t        vecs[21];
    exp_t        sb[$];
    exp_t        e;
    logic [31:0] last_addr, exp_addr, pend_addr;
    logic [31:0] prev_instr, prev_pc, prev_pcn;
    logic        pend, st, nreq;
    logic [31:0] naddr;

    initial begin
        //              st   red  rpc            rv   req  addr           instr          pc             pcn
        vecs[0]  = '{1'b0,1'b0,32'h0,         1'b0,1'b1,32'h0000_0100,NOP,          32'h0,         32'h0};
        vecs[1]  = '{1'b0,1'b0,32'h0,         1'b1,1'b1,32'h0000_0104,32'h0000_1007,32'h0000_0100,32'h0000_0104};
        vecs[2]  = '{1'b1,1'b0,32'h0,         1'b1,1'b0,32'h0,        32'h0000_1007,32'h0000_0100,32'h0000_0104};
        vecs[3]  = '{1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,        32'h0000_1007,32'h0000_0100,32'h0000_0104};
        vecs[4]  = '{1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,        32'h0000_1007,32'h0000_0100,32'h0000_0104};
        vecs[5]  = '{1'b0,1'b0,32'h0,         1'b0,1'b1,32'h0000_0108,32'h0000_1047,32'h0000_0104,32'h0000_0108};
        vecs[6]  = '{1'b0,1'b0,32'h0,         1'b1,1'b1,32'h0000_010C,32'h0000_1087,32'h0000_0108,32'h0000_010C};
        vecs[7]  = '{1'b0,1'b1,32'h0000_0203, 1'b0,1'b0,32'h0,        NOP,          32'h0000_0108,32'h0000_010C};
        vecs[8]  = '{1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,        NOP,          32'h0000_0108,32'h0000_010C};
        vecs[9]  = '{1'b0,1'b0,32'h0,         1'b0,1'b1,32'h0000_0200,NOP,          32'h0000_0108,32'h0000_010C};
        vecs[10] = '{1'b1,1'b1,32'h0000_0300, 1'b1,1'b0,32'h0,        NOP,          32'h0000_0108,32'h0000_010C};
        vecs[11] = '{1'b1,1'b0,32'h0,         1'b0,1'b0,32'h0,        NOP,          32'h0000_0108,32'h0000_010C};
        vecs[12] = '{1'b0,1'b0,32'h0,         1'b0,1'b1,32'h0000_0300,NOP,          32'h0000_0108,32'h0000_010C};
        vecs[13] = '{1'b0,1'b0,32'h0,         1'b1,1'b1,32'h0000_0304,32'h0000_3007,32'h0000_0300,32'h0000_0304};
        vecs[14] = '{1'b0,1'b0,32'h0,         1'b0,1'b0,32'h0,        NOP,          32'h0000_0300,32'h0000_0304};
        vecs[15] = '{1'b0,1'b0,32'h0,         1'b1,1'b1,32'h0000_0308,32'h0000_3047,32'h0000_0304,32'h0000_0308};
        vecs[16] = '{1'b0,1'b1,32'hFFFF_FFFC, 1'b0,1'b0,32'h0,        NOP,          32'h0000_0304,32'h0000_0308};
        vecs[17] = '{1'b0,1'b0,32'h0,         1'b1,1'b0,32'h0,        NOP,          32'h0000_0304,32'h0000_0308};
        vecs[18] = '{1'b0,1'b0,32'h0,         1'b0,1'b1,32'hFFFF_FFFC,NOP,          32'h0000_0304,32'h0000_0308};
        vecs[19] = '{1'b0,1'b0,32'h0,         1'b1,1'b1,32'h0000_0000,32'hFFFF_FFC7,32'hFFFF_FFFC,32'h0000_0000};
        vecs[20] = '{1'b0,1'b0,32'h0,         1'b1,1'b1,32'h0000_0004,32'h0000_0007,32'h0000_0000,32'h0000_0004};

        rstn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem.imem_rvalid = 1'b0; imem.imem_rdata = '0;
        last_addr = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_instr", instr_IF, NOP);
        check("rst_pc", pc_IF, 32'h0);
        check("rst_pcnext", pcnext_IF, 32'h0);
        check("rst_req", {31'd0, imem.imem_req}, 32'h0);
        check("rst_addr", imem.imem_addr, 32'h0000_0100);
        rstn = 1'b1;

        for (int i = 0; i < 21; i++) begin
            stall = vecs[i].st; redirect = vecs[i].red; redirect_pc = vecs[i].rpc;
            imem.imem_rvalid = vecs[i].rv; imem.imem_rdata = mem_word(last_addr);
            #1;
            check($sformatf("v%0d_req", i), {31'd0, imem.imem_req}, {31'd0, vecs[i].req});
            if (vecs[i].req) check($sformatf("v%0d_addr", i), imem.imem_addr, vecs[i].addr);
            nreq = imem.imem_req; naddr = imem.imem_addr;
            @(posedge clk); #1;
            if (nreq) last_addr = naddr;
            check($sformatf("v%0d_instr", i), instr_IF, vecs[i].instr);
            check($sformatf("v%0d_pc", i), pc_IF, vecs[i].pc);
            check($sformatf("v%0d_pcnext", i), pcnext_IF, vecs[i].pcn);
        end
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch", perf_fetch_cnt, 32'd7);
        check("perf_bubble", perf_bubble_cnt, 32'd4);
`endif

        // Reset asserted mid-WAIT, away from the clock edge.
        stall = 1'b0; redirect = 1'b0; imem.imem_rvalid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("midrst_instr", instr_IF, NOP);
        check("midrst_pc", pc_IF, 32'h0);
        check("midrst_pcnext", pcnext_IF, 32'h0);
        check("midrst_req", {31'd0, imem.imem_req}, 32'h0);
        check("midrst_addr", imem.imem_addr, 32'h0000_0100);
`ifdef FETCH_PERF_CNT_EN
        check("midrst_perf_fetch", perf_fetch_cnt, 32'h0);
        check("midrst_perf_bubble", perf_bubble_cnt, 32'h0);
`endif
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;

        // Scoreboard stream: 1-cycle memory, random stall, no redirects.
        exp_addr = 32'h0000_0100; pend = 1'b0; pend_addr = '0;
        prev_instr = NOP; prev_pc = '0; prev_pcn = '0;
        for (int i = 0; i < 300; i++) begin
            st = (i < 280) ? ($urandom_range(0, 3) == 0) : 1'b0;
            stall = st; redirect = 1'b0;
            imem.imem_rvalid = pend; imem.imem_rdata = mem_word(pend_addr);
            if (pend) sb.push_back('{mem_word(pend_addr), pend_addr, pend_addr + 32'd4});
            #1;
            if (imem.imem_req) begin
                check("stream_req_addr", imem.imem_addr, exp_addr);
                exp_addr = exp_addr + 32'd4;
            end
            nreq = imem.imem_req; naddr = imem.imem_addr;
            @(posedge clk); #1;
            pend = nreq; pend_addr = naddr;
            if (st) begin
                check("stall_hold_instr", instr_IF, prev_instr);
                check("stall_hold_pc", pc_IF, prev_pc);
            end else if (instr_IF !== NOP && (instr_IF !== prev_instr || pc_IF !== prev_pc)) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL sb_underflow: got instr %h with nothing expected", instr_IF);
                end else begin
                    e = sb.pop_front();
                    check("sb_instr", instr_IF, e.instr);
                    check("sb_pc", pc_IF, e.pc);
                    check("sb_pcnext", pcnext_IF, e.pcn);
                end
            end
            prev_instr = instr_IF; prev_pc = pc_IF; prev_pcn = pcnext_IF;
        end
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
